digitron_scan_display: RTL

DIGITRON_SCAN_DISPLAY -- requirements
Module: digitron_scan_display

---
 rtl/digitron_scan_display.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/digitron_scan_display.sv
// digitron_scan_display
//
// Multiplexed seven-segment driver. A loaded value is turned into one glyph
// per digit (hex nibbles directly, or decimal via a serial double-dabble
// conversion) and stored in a display buffer. A free-running prescaler then
// walks the digit selects and presents each buffered glyph in turn.
//
// Ports
//   CLK            sole clock, rising edge
//   RST            asynchronous, active-high reset
//   Data_In        unsigned value to display (DATA_W bits)
//   Load           one-cycle strobe capturing Data_In, Mode and Blank_En
//   Mode           0 = hexadecimal, 1 = decimal
//   Blank_En       1 = blank leading zero digits (digit 0 always shown)
//   Busy           decimal conversion in progress
//   Digitron_Out   registered segments {dp,g,f,e,d,c,b,a}, active-high
//   DigitronCS_Out registered digit selects, active-low, bit 0 = LS digit
//
// Load/Busy handshake: Load is accepted on an edge where Busy is low and no
// previously accepted Load is still waiting for its first processing edge;
// otherwise it is dropped without touching the conversion in flight. Hex
// loads commit one edge after acceptance. Decimal loads raise Busy on the
// next edge, hold it for DATA_W cycles (one conversion step each) and commit
// the buffer on the edge where Busy falls.

module digitron_scan_display #(
  parameter int DIGITS   = 6,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 200
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Load,
  input  logic              Mode,
  input  logic              Blank_En,
  output logic              Busy,
  output logic [7:0]        Digitron_Out,
  output logic [DIGITS-1:0] DigitronCS_Out
);

  // Ten BCD digits cover any DATA_W up to 32 bits, so overflow is judged by
  // looking at BCD digits above the displayed range.
  localparam int BCD_N = 10;
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW    = $clog2(DATA_W + 1);

  logic [PW-1:0]         pre_q;
  logic [IW-1:0]         idx_q;
  logic                  pend_q;
  logic                  busy_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_W-1:0]     val_q;     // captured value; shift register in decimal mode
  logic [4*BCD_N-1:0]    bcd_q;
  logic                  mode_q;
  logic                  blank_q;
  logic [7*DIGITS-1:0]   disp_q;    // one 7-bit glyph per digit
  logic [7:0]            seg_q;
  logic [DIGITS-1:0]     cs_q;

  logic [4*BCD_N-1:0]    bcd_adj;
  logic [4*BCD_N-1:0]    bcd_nxt;
  logic [DATA_W-1:0]     bin_nxt;
  logic [7*DIGITS-1:0]   new_disp;
  logic [6:0]            cur_glyph;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
  // whole {bcd, binary} pair left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int j = 0; j < BCD_N; j++) begin
      if (bcd_q[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj[4*BCD_N-2:0], val_q, 1'b0};
  end

  // Glyphs for the buffer, built from whichever source the captured mode
  // selects. In decimal mode this is only sampled once the conversion is done.
  always_comb begin
    logic [4*DIGITS-1:0] digs;
    logic [63:0]         pad;
    logic                ovf;
    logic                seen;
    digs     = '0;
    pad      = 64'(val_q);
    ovf      = 1'b0;
    seen     = 1'b0;
    new_disp = '0;
    if (mode_q) begin
      for (int i = 0; i < DIGITS; i++) digs[4*i +: 4] = bcd_q[4*i +: 4];
      ovf = |bcd_q[4*BCD_N-1:4*DIGITS];
    end else begin
      for (int i = 0; i < DIGITS; i++) digs[4*i +: 4] = pad[4*i +: 4];
      ovf = |(pad >> (4*DIGITS));
    end
    // Walk from the top digit down; 'seen' marks the first nonzero digit.
    for (int i = DIGITS-1; i >= 0; i--) begin
      if (digs[4*i +: 4] != 4'd0) seen = 1'b1;
      if (ovf)                                 new_disp[7*i +: 7] = 7'h40;
      else if (blank_q && !seen && (i != 0))   new_disp[7*i +: 7] = 7'h00;
      else                                     new_disp[7*i +: 7] = seg7(digs[4*i +: 4]);
    end
  end

  always_comb begin
    cur_glyph = 7'h00;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_glyph = disp_q[7*i +: 7];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      val_q   <= '0;
      bcd_q   <= '0;
      mode_q  <= 1'b0;
      blank_q <= 1'b0;
      disp_q  <= {DIGITS{7'h3F}};
      seg_q   <= 8'h00;
      cs_q    <= '1;
    end else begin
      // Scan: idx_q names the digit shown at the next tick, so the first
      // tick after reset presents digit 0.
      if (pre_q == PW'(SCAN_DIV-1)) begin
        pre_q <= '0;
        seg_q <= {1'b0, cur_glyph};
        cs_q  <= ~(DIGITS'(1) << idx_q);
        idx_q <= (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end

      if (Load && !busy_q && !pend_q) begin
        val_q   <= Data_In;
        bcd_q   <= '0;
        mode_q  <= Mode;
        blank_q <= Blank_En;
        pend_q  <= 1'b1;
      end else if (pend_q) begin
        pend_q <= 1'b0;
        if (!mode_q) begin
          disp_q <= new_disp;
        end else begin
          busy_q <= 1'b1;
          cnt_q  <= CW'(1);
          bcd_q  <= bcd_nxt;
          val_q  <= bin_nxt;
        end
      end else if (busy_q) begin
        if (cnt_q == CW'(DATA_W)) begin
          busy_q <= 1'b0;
          disp_q <= new_disp;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          bcd_q <= bcd_nxt;
          val_q <= bin_nxt;
        end
      end
    end
  end

  assign Busy           = busy_q;
  assign Digitron_Out   = seg_q;
  assign DigitronCS_Out = cs_q;

endmodule
